// File: rtl/ram_arbiter.sv
// Two-requester (CPU=r0, DMA=r1) round-robin arbiter in front of a single-port RAM.
// One transaction in flight; each completion is reported by rvalid (read) or err (timeout).
module ram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  output logic              o_r0_gnt,
  output logic [DATA_W-1:0] o_r0_rdata,
  output logic              o_r0_rvalid,
  output logic              o_r0_err,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  output logic              o_r1_gnt,
  output logic [DATA_W-1:0] o_r1_rdata,
  output logic              o_r1_rvalid,
  output logic              o_r1_err,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  output logic              o_ram_wr_en,
  output logic              o_ram_rd_en,
  input  logic              i_ram_busy,
  input  logic              i_ram_rd_ready,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic [1:0]        o_dbg_state
);

  // Handshakes: a requester holds req (with we/addr/wdata stable) until its one-cycle
  // gnt; the RAM takes a strobe only on an edge where busy=0 and returns read data on
  // the edge where rd_ready=1. All outputs are registered.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WR, S_WAIT_RD} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t              r_state, w_state_nxt;
  logic                r_last, r_sel, r_we;
  logic [7:0]          r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata0, r_rdata1;
  logic [1:0]          r_gnt, r_rvalid, r_err;
  logic [1:0]          w_gnt_nxt, w_rvalid_nxt, w_err_nxt;
  logic                r_wr_en, r_rd_en, w_wr_en_nxt, w_rd_en_nxt;
  logic                w_take, w_winner, w_rd_load;

  assign w_cnt_inc = r_cnt + 8'd1;
  // On a tie the requester not granted last wins; a lone requester always wins.
  assign w_winner  = (i_r0_req && i_r1_req) ? ~r_last : i_r1_req;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_take       = 1'b0;
    w_rd_load    = 1'b0;
    w_gnt_nxt    = '0;
    w_rvalid_nxt = '0;
    w_err_nxt    = '0;
    w_wr_en_nxt  = 1'b0;
    w_rd_en_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_r0_req || i_r1_req) begin
          w_take              = 1'b1;
          w_gnt_nxt[w_winner] = 1'b1;
          w_state_nxt         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_ram_busy) begin
          w_wr_en_nxt = r_we;
          w_rd_en_nxt = ~r_we;
          w_state_nxt = r_we ? S_WAIT_WR : S_WAIT_RD;
        end
      end
      S_WAIT_WR: begin
        w_cnt_nxt = w_cnt_inc;
        // The first edge after the strobe (count 0) is busy settling time.
        if (r_cnt != 8'd0 && !i_ram_busy) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_inc == TO) begin
          w_err_nxt[r_sel] = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        w_cnt_nxt = w_cnt_inc;
        if (i_ram_rd_ready) begin
          w_rd_load           = 1'b1;
          w_rvalid_nxt[r_sel] = 1'b1;
          w_state_nxt         = S_IDLE;
        end else if (w_cnt_inc == TO) begin
          w_err_nxt[r_sel] = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_err    <= w_err_nxt;
      r_wr_en  <= w_wr_en_nxt;
      r_rd_en  <= w_rd_en_nxt;
      if (w_take) begin
        r_sel   <= w_winner;
        r_last  <= w_winner;
        r_we    <= w_winner ? i_r1_we    : i_r0_we;
        r_addr  <= w_winner ? i_r1_addr  : i_r0_addr;
        r_wdata <= w_winner ? i_r1_wdata : i_r0_wdata;
      end
      if (w_rd_load) begin
        if (r_sel) r_rdata1 <= i_ram_rd_data;
        else       r_rdata0 <= i_ram_rd_data;
      end
    end
  end

  assign o_r0_gnt      = r_gnt[0];
  assign o_r1_gnt      = r_gnt[1];
  assign o_r0_rvalid   = r_rvalid[0];
  assign o_r1_rvalid   = r_rvalid[1];
  assign o_r0_err      = r_err[0];
  assign o_r1_err      = r_err[1];
  assign o_r0_rdata    = r_rdata0;
  assign o_r1_rdata    = r_rdata1;
  assign o_ram_addr    = r_addr;
  assign o_ram_wr_data = r_wdata;
  assign o_ram_wr_en   = r_wr_en;
  assign o_ram_rd_en   = r_rd_en;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with a monitor that checks every
// gnt/strobe/rvalid/err event, in order, against an expected-event queue.
module tb_ram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam logic [3:0] K_GNT = 4'd1, K_WR = 4'd2, K_RD = 4'd3, K_RV = 4'd4, K_ERR = 4'd5;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT_WR = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic ram_wr_en, ram_rd_en;
  logic ram_busy = 0, ram_rd_ready = 0;
  logic [DW-1:0] ram_rd_data = '0;
  logic [1:0] dbg_state;

  logic [47:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_cyc = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
    .o_r0_gnt(r0_gnt), .o_r0_rdata(r0_rdata), .o_r0_rvalid(r0_rvalid), .o_r0_err(r0_err),
    .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
    .o_r1_gnt(r1_gnt), .o_r1_rdata(r1_rdata), .o_r1_rvalid(r1_rvalid), .o_r1_err(r1_err),
    .o_ram_addr(ram_addr), .o_ram_wr_data(ram_wr_data),
    .o_ram_wr_en(ram_wr_en), .o_ram_rd_en(ram_rd_en),
    .i_ram_busy(ram_busy), .i_ram_rd_ready(ram_rd_ready), .i_ram_rd_data(ram_rd_data),
    .o_dbg_state(dbg_state)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] ev(input logic [3:0] k, input logic [3:0] id,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {k, id, a, d};
  endfunction

  // Monitor: at most one event per cycle, compared in order against exp_q.
  always @(negedge clk) begin
    logic [7:0]  pulses;
    logic [47:0] got;
    pulses = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, ram_wr_en, ram_rd_en};
    if (|pulses) begin
      chk("excl", 48'($countones(pulses) <= 1), 48'd1);
      if (r0_gnt)         got = ev(K_GNT, 4'd0, '0, '0);
      else if (r1_gnt)    got = ev(K_GNT, 4'd1, '0, '0);
      else if (ram_wr_en) got = ev(K_WR, 4'd0, ram_addr, ram_wr_data);
      else if (ram_rd_en) got = ev(K_RD, 4'd0, ram_addr, '0);
      else if (r0_rvalid) got = ev(K_RV, 4'd0, '0, r0_rdata);
      else if (r1_rvalid) got = ev(K_RV, 4'd1, '0, r1_rdata);
      else if (r0_err)    got = ev(K_ERR, 4'd0, '0, '0);
      else                got = ev(K_ERR, 4'd1, '0, '0);
      if (r0_gnt || r1_gnt) gnt_cyc = cyc;
      if (ram_wr_en || ram_rd_en) chk("lat", 48'((cyc - gnt_cyc + 1) >= 2), 48'd1);
      if (exp_q.size() == 0) chk("unexpected_evt", got, '0);
      else chk("evt", got, exp_q.pop_front());
    end
  end

  // what: 0 gnt0, 1 gnt1, 2 wr_en, 3 rd_en, 4 any rvalid, 5 any err
  task automatic wait_for(input int what, output int c);
    logic seen;
    seen = 1'b0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      case (what)
        0: seen = r0_gnt;
        1: seen = r1_gnt;
        2: seen = ram_wr_en;
        3: seen = ram_rd_en;
        4: seen = r0_rvalid | r1_rvalid;
        default: seen = r0_err | r1_err;
      endcase
      if (seen) begin
        c = cyc;
        return;
      end
    end
    chk($sformatf("wait_%0d", what), 48'(seen), 48'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_pulses"}, 48'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err,
                               ram_wr_en, ram_rd_en}), 48'd0);
    chk({pfx, "_addr"}, 48'(ram_addr), 48'd0);
    chk({pfx, "_wdata"}, 48'(ram_wr_data), 48'd0);
    chk({pfx, "_rdata0"}, 48'(r0_rdata), 48'd0);
    chk({pfx, "_rdata1"}, 48'(r1_rdata), 48'd0);
    chk({pfx, "_state"}, 48'(dbg_state), 48'(ST_IDLE));
  endtask

  task automatic drive_req(input int id, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    if (id == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = d; end
    else         begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = d; end
  endtask

  initial begin
    int c, ks, ke, ng;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 0;

    // r0 write 0x10 / 0xBEEF, busy after strobe to exercise WAIT_WR
    @(negedge clk);
    drive_req(0, 1'b1, 24'h000010, 16'hBEEF);
    exp_q.push_back(ev(K_GNT, 4'd0, '0, '0));
    exp_q.push_back(ev(K_WR, 4'd0, 24'h000010, 16'hBEEF));
    @(posedge clk); #1;
    chk("w_gnt0", 48'(r0_gnt), 48'd1);
    chk("w_gnt1", 48'(r1_gnt), 48'd0);
    @(negedge clk) r0_req = 0;
    @(posedge clk); #1;
    chk("w_stb", 48'({ram_wr_en, ram_rd_en}), 48'b10);
    chk("w_addr", 48'(ram_addr), 48'h000010);
    chk("w_data", 48'(ram_wr_data), 48'hBEEF);
    @(negedge clk) ram_busy = 1;
    @(posedge clk); #1;
    chk("w_stb_once", 48'(ram_wr_en), 48'd0);
    @(posedge clk); #1;
    chk("w_wait", 48'(dbg_state), 48'(ST_WAIT_WR));
    chk("w_addr_hold", 48'(ram_addr), 48'h000010);
    @(negedge clk) ram_busy = 0;
    @(posedge clk); #1;
    chk("w_idle", 48'(dbg_state), 48'(ST_IDLE));

    // r1 read 0x20, data 0x1234 arriving late
    @(negedge clk);
    drive_req(1, 1'b0, 24'h000020, '0);
    exp_q.push_back(ev(K_GNT, 4'd1, '0, '0));
    exp_q.push_back(ev(K_RD, 4'd0, 24'h000020, '0));
    exp_q.push_back(ev(K_RV, 4'd1, '0, 16'h1234));
    wait_for(1, c);
    r1_req = 0;
    wait_for(3, c);
    @(negedge clk);
    ram_rd_ready = 1; ram_rd_data = 16'h1234;
    wait_for(4, c);
    ram_rd_ready = 0;
    chk("r_rdata1", 48'(r1_rdata), 48'h1234);
    chk("r_rdata0", 48'(r0_rdata), 48'h0);
    ram_rd_ready = 1; ram_rd_data = 16'h5555;
    @(negedge clk) ram_rd_ready = 0;
    @(negedge clk);
    chk("r_hold", 48'(r1_rdata), 48'h1234);

    // reset, then both requesters continuously: r0, r1, r0, r1
    rst = 1;
    @(negedge clk);
    check_zero("rst2");
    rst = 0;
    a0 = 24'($urandom_range(0, 24'hFFFFFF)); d0 = 16'($urandom_range(1, 16'hFFFF));
    a1 = 24'($urandom_range(0, 24'hFFFFFF)); d1 = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ev(K_GNT, 4'd0, '0, '0));
      exp_q.push_back(ev(K_WR, 4'd0, a0, d0));
      exp_q.push_back(ev(K_GNT, 4'd1, '0, '0));
      exp_q.push_back(ev(K_WR, 4'd0, a1, d1));
    end
    drive_req(0, 1'b1, a0, d0);
    drive_req(1, 1'b1, a1, d1);
    ng = 0;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      @(negedge clk);
      if (r0_gnt || r1_gnt) ng++;
    end
    r0_req = 0; r1_req = 0;
    chk("rr_gnts", 48'(ng), 48'd4);
    wait_drain();

    // busy held during ISSUE
    a1 = 24'($urandom_range(0, 24'hFFFFFF)); d1 = 16'($urandom_range(1, 16'hFFFF));
    @(negedge clk);
    ram_busy = 1;
    drive_req(1, 1'b1, a1, d1);
    exp_q.push_back(ev(K_GNT, 4'd1, '0, '0));
    exp_q.push_back(ev(K_WR, 4'd0, a1, d1));
    wait_for(1, c);
    r1_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_stb", 48'({ram_wr_en, ram_rd_en}), 48'd0);
      chk("busy_addr", 48'(ram_addr), 48'(a1));
    end
    ram_busy = 0;
    wait_drain();

    // read timeout, then a normal r0 read
    a0 = 24'($urandom_range(0, 24'hFFFFFF));
    @(negedge clk);
    drive_req(0, 1'b0, a0, '0);
    exp_q.push_back(ev(K_GNT, 4'd0, '0, '0));
    exp_q.push_back(ev(K_RD, 4'd0, a0, '0));
    exp_q.push_back(ev(K_ERR, 4'd0, '0, '0));
    wait_for(0, c);
    r0_req = 0;
    wait_for(3, ks);
    wait_for(5, ke);
    chk("to_lat", 48'(ke - ks), 48'd4);
    a0 = 24'($urandom_range(0, 24'hFFFFFF)); d0 = 16'($urandom_range(1, 16'hFFFF));
    @(negedge clk);
    drive_req(0, 1'b0, a0, '0);
    exp_q.push_back(ev(K_GNT, 4'd0, '0, '0));
    exp_q.push_back(ev(K_RD, 4'd0, a0, '0));
    exp_q.push_back(ev(K_RV, 4'd0, '0, d0));
    wait_for(0, c);
    r0_req = 0;
    wait_for(3, c);
    ram_rd_ready = 1; ram_rd_data = d0;
    wait_for(4, c);
    ram_rd_ready = 0;
    chk("to_next_rdata", 48'(r0_rdata), 48'(d0));

    // reset in WAIT_RD aborts silently
    a0 = 24'($urandom_range(1, 24'hFFFFFF));
    @(negedge clk);
    drive_req(0, 1'b0, a0, '0);
    exp_q.push_back(ev(K_GNT, 4'd0, '0, '0));
    exp_q.push_back(ev(K_RD, 4'd0, a0, '0));
    wait_for(0, c);
    r0_req = 0;
    wait_for(3, c);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    check_zero("abort");
    @(negedge clk);
    rst = 0;
    ram_rd_ready = 1; ram_rd_data = 16'($urandom_range(1, 16'hFFFF));
    repeat (3) @(negedge clk);
    ram_rd_ready = 0;
    repeat (2) @(negedge clk);
    chk("abort_rdata0", 48'(r0_rdata), 48'd0);
    chk("final_drain", 48'(exp_q.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
